// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if
//   Bundles the divisor-programming and channel-control signals of the UART
//   baud-tick generator.
//   master : drives div_int/div_frac/div_load/rx_en/tx_en, observes the rest
//   slave  : the generator itself
//   Signals:
//     div_int     DIV_W   requested integer divisor (clk cycles per bit)
//     div_frac    FRAC_W  requested fractional divisor (1/2^FRAC_W steps)
//     div_load    1       one-cycle strobe capturing div_int/div_frac
//     rx_en       1       RX channel run, held for the whole frame
//     tx_en       1       TX channel run, held for the whole frame
//     rx_tick     1       one-cycle pulse at bit centre
//     tx_tick     1       one-cycle pulse at bit end
//     cfg_pending 1       a loaded divisor waits for both channels idle
//     div_active  DIV_W   integer divisor currently in use
interface uart_baud_gen_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              rx_en;
  logic              tx_en;
  logic              rx_tick;
  logic              tx_tick;
  logic              cfg_pending;
  logic [DIV_W-1:0]  div_active;

  modport master (
    output div_int, div_frac, div_load, rx_en, tx_en,
    input  rx_tick, tx_tick, cfg_pending, div_active
  );

  modport slave (
    input  div_int, div_frac, div_load, rx_en, tx_en,
    output rx_tick, tx_tick, cfg_pending, div_active
  );
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   UART baud-tick generator with independent RX and TX channels sharing one
//   runtime-programmable divisor (integer part plus FRAC_W-bit fraction).
//   The RX channel pulses at mid-bit, the TX channel at each bit boundary.
//   A divisor load is applied at once when both channels are idle, otherwise
//   it is held in a shadow register until they both are.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    uart_baud_gen_if.slave (divisor load, channel enables, ticks,
//            cfg_pending, div_active)

// One tick channel. Counts 0..P-1 while en is high; P = div, or div+1 when
// the fractional accumulator carried out on the previous wrap.
// MID=1 pulses when the count reaches div>>1 (bit centre), MID=0 on wrap.
module uart_baud_chan #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter bit MID    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [FRAC_W-1:0] frac,
  output logic              tick
);
  logic [DIV_W-1:0]  cnt_p0;
  logic [FRAC_W-1:0] acc_p0;
  logic              ext_p0;
  logic              tick_p1;

  logic [DIV_W-1:0]  last_cnt;
  logic [FRAC_W:0]   acc_sum;
  logic              wrap;
  logic              hit;

  // div is never below 2, so div-1+ext cannot overflow DIV_W bits
  assign last_cnt = div - DIV_W'(1) + DIV_W'(ext_p0);
  assign acc_sum  = {1'b0, acc_p0} + {1'b0, frac};
  assign wrap     = (cnt_p0 == last_cnt);
  assign hit      = MID ? (cnt_p0 == (div >> 1)) : wrap;

  // ---- stage p0 -> p1: period counter, fraction accumulator, tick register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= '0;
      acc_p0  <= '0;
      ext_p0  <= 1'b0;
      tick_p1 <= 1'b0;
    end else if (!en) begin
      cnt_p0  <= '0;
      acc_p0  <= '0;
      ext_p0  <= 1'b0;
      tick_p1 <= 1'b0;
    end else begin
      tick_p1 <= hit;
      if (wrap) begin
        cnt_p0 <= '0;
        acc_p0 <= acc_sum[FRAC_W-1:0];
        ext_p0 <= acc_sum[FRAC_W];
      end else begin
        cnt_p0 <= cnt_p0 + DIV_W'(1);
      end
    end
  end

  assign tick = tick_p1;
endmodule

module uart_baud_gen #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int DEFAULT_DIV  = 50,
  parameter int DEFAULT_FRAC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_baud_gen_if.slave     bus
);
  logic [DIV_W-1:0]  div_active;
  logic [FRAC_W-1:0] frac_active;
  logic [DIV_W-1:0]  shadow_div;
  logic [FRAC_W-1:0] shadow_frac;
  logic              pending;
  logic              idle;

  // A divisor below 2 would leave no room for a mid-bit tick
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    clamp_div = (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  // Divisor may only change while neither channel is mid-frame
  assign idle = !bus.rx_en && !bus.tx_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_active  <= DIV_W'(DEFAULT_DIV);
      frac_active <= FRAC_W'(DEFAULT_FRAC);
      shadow_div  <= DIV_W'(DEFAULT_DIV);
      shadow_frac <= FRAC_W'(DEFAULT_FRAC);
      pending     <= 1'b0;
    end else if (bus.div_load) begin
      if (idle) begin
        div_active  <= clamp_div(bus.div_int);
        frac_active <= bus.div_frac;
        pending     <= 1'b0;
      end else begin
        // a later load simply overwrites an earlier one still waiting
        shadow_div  <= clamp_div(bus.div_int);
        shadow_frac <= bus.div_frac;
        pending     <= 1'b1;
      end
    end else if (pending && idle) begin
      div_active  <= shadow_div;
      frac_active <= shadow_frac;
      pending     <= 1'b0;
    end
  end

  uart_baud_chan #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .MID(1'b1)) u_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.rx_en),
    .div   (div_active),
    .frac  (frac_active),
    .tick  (bus.rx_tick)
  );

  uart_baud_chan #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .MID(1'b0)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.tx_en),
    .div   (div_active),
    .frac  (frac_active),
    .tick  (bus.tx_tick)
  );

  assign bus.cfg_pending = pending;
  assign bus.div_active  = div_active;
endmodule

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen
//   Directed bench for uart_baud_gen: reset defaults, RX/TX tick phase,
//   fractional period averaging, deferred divisor loads, clamping and
//   asynchronous reset. Inputs change on the falling edge; outputs are
//   observed on the falling edge.
module tb_uart_baud_gen;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;
  int   rx_cnt;
  int   tx_cnt;

  uart_baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bif ();

  uart_baud_gen #(
    .DIV_W(16), .FRAC_W(4), .DEFAULT_DIV(50), .DEFAULT_FRAC(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bif.rx_tick) rx_cnt++;
    if (bif.tx_tick) tx_cnt++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic load(input int d, input int f);
    bif.div_int  = 16'(d);
    bif.div_frac = 4'(f);
    bif.div_load = 1'b1;
    @(negedge clk);
    bif.div_load = 1'b0;
  endtask

  // Counts rising edges until the chosen tick is seen high; -1 on timeout.
  task automatic wait_tick(input bit use_tx, input int max_edges, output int edges);
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < max_edges) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = use_tx ? bif.tx_tick : bif.rx_tick;
    end
    if (!seen) edges = -1;
  endtask

  initial begin
    int e;
    int sum;
    int iv[32];
    int rx_snap;
    n_chk  = 0;
    n_pass = 0;
    rx_cnt = 0;
    tx_cnt = 0;
    rst_n = 1'b0;
    bif.div_int  = '0;
    bif.div_frac = '0;
    bif.div_load = 1'b0;
    bif.rx_en    = 1'b0;
    bif.tx_en    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_tick", bif.rx_tick, 0);
    check("rst_tx_tick", bif.tx_tick, 0);
    check("rst_pending", bif.cfg_pending, 0);
    check("rst_div_active", bif.div_active, 50);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: default divisor, RX mid-bit ticks at 26, 76, 126
    bif.rx_en = 1'b1;
    wait_tick(1'b0, 200, e); check("rx_first", e, 26);
    wait_tick(1'b0, 200, e); check("rx_second", e, 50);
    wait_tick(1'b0, 200, e); check("rx_third", e, 50);
    bif.rx_en = 1'b0;
    @(negedge clk);

    // 2: TX bit-end ticks at 50, 100, 150 with RX idle
    rx_snap = rx_cnt;
    bif.tx_en = 1'b1;
    wait_tick(1'b1, 200, e); check("tx_first", e, 50);
    wait_tick(1'b1, 200, e); check("tx_second", e, 50);
    wait_tick(1'b1, 200, e); check("tx_third", e, 50);
    check("rx_quiet", rx_cnt, rx_snap);
    bif.tx_en = 1'b0;
    @(negedge clk);

    // 3: D=10 frac=8/16 -> periods 10,10,11,10,11,...
    load(10, 8);
    check("frac_div_active", bif.div_active, 10);
    check("frac_pending", bif.cfg_pending, 0);
    bif.tx_en = 1'b1;
    wait_tick(1'b1, 50, e); check("frac_first", e, 10);
    sum = 0;
    for (int i = 0; i < 32; i++) begin
      wait_tick(1'b1, 50, iv[i]);
      sum += iv[i];
    end
    check("frac_iv0", iv[0], 10);
    check("frac_iv1", iv[1], 11);
    check("frac_iv2", iv[2], 10);
    check("frac_iv3", iv[3], 11);
    check("frac_span32", sum, 336);
    bif.tx_en = 1'b0;
    @(negedge clk);

    // 4: load during a running frame is deferred
    load(50, 0);
    bif.rx_en = 1'b1;
    load(20, 0);
    check("defer_pending", bif.cfg_pending, 1);
    check("defer_div_hold", bif.div_active, 50);
    wait_tick(1'b0, 200, e); check("defer_rx_old", e, 25);
    check("defer_div_hold2", bif.div_active, 50);
    bif.rx_en = 1'b0;
    @(negedge clk);
    check("defer_div_applied", bif.div_active, 20);
    check("defer_pending_clr", bif.cfg_pending, 0);
    bif.rx_en = 1'b1;
    wait_tick(1'b0, 100, e); check("defer_rx_new", e, 11);
    bif.rx_en = 1'b0;
    @(negedge clk);

    // 5: clamp to 2, then last of two pending loads wins
    load(0, 0);
    check("clamp_div", bif.div_active, 2);
    bif.rx_en = 1'b1;
    wait_tick(1'b0, 20, e); check("clamp_rx_first", e, 2);
    wait_tick(1'b0, 20, e); check("clamp_rx_second", e, 2);
    load(30, 0);
    load(40, 0);
    check("two_load_pending", bif.cfg_pending, 1);
    check("two_load_hold", bif.div_active, 2);
    bif.rx_en = 1'b0;
    @(negedge clk);
    check("two_load_last", bif.div_active, 40);
    bif.rx_en = 1'b1;
    wait_tick(1'b0, 100, e); check("two_load_rx", e, 21);
    bif.rx_en = 1'b0;
    @(negedge clk);

    // 6: async reset mid-frame with a load pending and a tick high
    load(50, 0);
    bif.rx_en = 1'b1;
    bif.tx_en = 1'b1;
    load(20, 0);
    check("ar_pending_before", bif.cfg_pending, 1);
    wait_tick(1'b0, 200, e); check("ar_rx_pre", e, 25);
    #1 rst_n = 1'b0;
    #1;
    check("ar_rx_tick", bif.rx_tick, 0);
    check("ar_tx_tick", bif.tx_tick, 0);
    check("ar_pending", bif.cfg_pending, 0);
    check("ar_div_active", bif.div_active, 50);
    bif.rx_en = 1'b0;
    bif.tx_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_div_after", bif.div_active, 50);
    check("ar_pending_after", bif.cfg_pending, 0);
    bif.rx_en = 1'b1;
    wait_tick(1'b0, 200, e); check("ar_rx_restart", e, 26);
    bif.rx_en = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
